// File: rtl/ysyx_imem_rsp_if.sv
// ysyx_imem_rsp_if: IFU read channel between the fetch unit (master) and the instruction memory responder (slave).
interface ysyx_imem_rsp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rerr;
  modport master (output araddr, arvalid, input rdata, rvalid, rerr);
  modport slave  (input araddr, arvalid, output rdata, rvalid, rerr);
endinterface

// File: rtl/ysyx_imem_rsp.sv
// ysyx_imem_rsp: IFU instruction-memory responder with programmable latency and a word preload port.
// Define YSYX_IMEM_RAND_DELAY_EN to add 0..3 pseudo-random extra wait cycles per fetch.
module ysyx_imem_rsp #(
  parameter int              ADDR_W  = 32,
  parameter int              DATA_W  = 32,
  parameter int              DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE  = 'h8000_0000,
  parameter int              LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_imem_rsp_if.slave      ifu,
  input  logic                load_en,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [DATA_W-1:0]   load_data,
  output logic                busy_o
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d, cnt_ld;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic              accept, rd_err, ld_err;
  logic [ADDR_W-1:0] rd_off, ld_off;
  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_off = req_addr_d - BASE;
  assign ld_off = load_addr - BASE;
  assign rd_err = (rd_off[1:0] != 2'b0) || (req_addr_d < BASE) || (rd_off[ADDR_W-1:IW+2] != '0);
  assign ld_err = (ld_off[1:0] != 2'b0) || (load_addr < BASE) || (ld_off[ADDR_W-1:IW+2] != '0);
  // DRAIN re-accepts only a different address, since the master holds arvalid after rvalid
  assign accept = ifu.arvalid && (state_q == IDLE || (state_q == DRAIN && ifu.araddr != req_addr_q));

`ifdef YSYX_IMEM_RAND_DELAY_EN
  logic [3:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  assign cnt_ld = 8'(LATENCY - 1) + {6'b0, lfsr_q[1:0]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr_q <= 4'b1001;
    else      lfsr_q <= lfsr_d;
`else
  assign cnt_ld = 8'(LATENCY - 1);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_addr_d = req_addr_q;
    rvalid_d   = 1'b0;
    rerr_d     = rerr_q;
    rdata_d    = rdata_q;
    if (accept) begin
      req_addr_d = ifu.araddr;
      cnt_d      = cnt_ld;
      state_d    = cnt_ld == 8'd0 ? RESP : WAIT;
    end else if (state_q == WAIT) begin
      cnt_d   = cnt_q - 8'd1;
      state_d = cnt_q <= 8'd1 ? RESP : WAIT;
    end else if (state_q == RESP) begin
      state_d = DRAIN;
    end else if (state_q == DRAIN && !ifu.arvalid) begin
      state_d = IDLE;
    end
    // memory is sampled here, before any same-edge preload lands: read-before-write
    if (state_d == RESP) begin
      rvalid_d = 1'b1;
      rerr_d   = rd_err;
      rdata_d  = rd_err ? '0 : mem[rd_off[IW+1:2]];
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      rerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      rerr_q     <= rerr_d;
    end

  always_ff @(posedge clk)
    if (load_en && !ld_err) mem[ld_off[IW+1:2]] <= load_data;

  assign ifu.rvalid = rvalid_q;
  assign ifu.rerr   = rerr_q;
  assign ifu.rdata  = rdata_q;
  assign busy_o     = state_q == WAIT || state_q == RESP;
endmodule

// File: tb/tb_ysyx_imem_rsp.sv
// tb_ysyx_imem_rsp: directed and randomized fetches on LATENCY=2 and LATENCY=8 responders against a word-array model.
module tb_ysyx_imem_rsp;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 1024;
`ifdef YSYX_IMEM_RAND_DELAY_EN
  localparam int EXTRA = 3;
`else
  localparam int EXTRA = 0;
`endif
  logic clk = 1'b0;
  logic rst2 = 1'b0, rst8 = 1'b0;
  logic load_en = 1'b0;
  logic [31:0] load_addr = '0, load_data = '0;
  logic busy2, busy8;
  bit sel = 1'b0;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] mdl [DEPTH];

  ysyx_imem_rsp_if #(.ADDR_W(32), .DATA_W(32)) if2 ();
  ysyx_imem_rsp_if #(.ADDR_W(32), .DATA_W(32)) if8 ();

  ysyx_imem_rsp #(.LATENCY(2)) u2 (.clk(clk), .rst(rst2), .ifu(if2), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy_o(busy2));
  ysyx_imem_rsp #(.LATENCY(8)) u8 (.clk(clk), .rst(rst8), .ifu(if8), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy_o(busy8));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic bit m_err(logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || ((a - BASE) / 4 >= DEPTH);
  endfunction
  function automatic int m_idx(logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction
  function automatic logic [31:0] exp_data(logic [31:0] a);
    return m_err(a) ? 32'h0 : mdl[m_idx(a)];
  endfunction

  function automatic logic o_rv();
    return sel ? if8.rvalid : if2.rvalid;
  endfunction
  function automatic logic o_re();
    return sel ? if8.rerr : if2.rerr;
  endfunction
  function automatic logic [31:0] o_rd();
    return sel ? if8.rdata : if2.rdata;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(bit s, logic [31:0] a, bit v);
    if (s) begin if8.araddr = a; if8.arvalid = v; end
    else   begin if2.araddr = a; if2.arvalid = v; end
  endtask

  task automatic load(logic [31:0] a, logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk);
    #1 load_en = 1'b0;
    if (!m_err(a)) mdl[m_idx(a)] = d;
  endtask

  task automatic fetch(string tag, bit s, logic [31:0] a, bit keep);
    int lat, lo;
    sel = s;
    lo = s ? 8 : 2;
    @(negedge clk);
    drive(s, a, 1'b1);
    @(posedge clk);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!o_rv() && lat < 300);
    n_cmp++;
    assert (lat >= lo && lat <= lo + EXTRA) else begin
      n_bad++;
      $error("FAIL %s_lat: observed %0d expected %0d..%0d", tag, lat, lo, lo + EXTRA);
    end
    chk({tag, "_rvalid"}, 32'(o_rv()), 32'd1);
    chk({tag, "_rdata"}, o_rd(), exp_data(a));
    chk({tag, "_rerr"}, 32'(o_re()), 32'(m_err(a)));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(o_rv()), 32'd0);
    if (!keep) drive(s, a, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [31:0] a, old;
    drive(0, '0, 0);
    drive(1, '0, 0);
    repeat (3) @(negedge clk);
    chk("rst2_rvalid", 32'(if2.rvalid), 0);
    chk("rst2_rerr", 32'(if2.rerr), 0);
    chk("rst2_rdata", if2.rdata, 0);
    chk("rst2_busy", 32'(busy2), 0);
    chk("rst8_rvalid", 32'(if8.rvalid), 0);
    chk("rst8_busy", 32'(busy8), 0);
    rst2 = 1'b1; rst8 = 1'b1;

    for (int i = 0; i < 64; i++) load(BASE + 32'(4 * i), $urandom);
    load(BASE, 32'h0000_0413);
    load(32'h8000_1000, $urandom);
    load(32'h8000_0006, $urandom);
    load(32'h7FFF_FFFC, $urandom);

    fetch("fixed", 0, BASE, 1);
    cnt = 0;
    repeat (10) begin @(negedge clk); cnt += int'(if2.rvalid) + int'(busy2); end
    chk("held_no_resp", 32'(cnt), 0);
    fetch("rearm", 0, BASE + 4, 0);

    fetch("err_misalign", 0, 32'h8000_0002, 0);
    fetch("err_top", 0, 32'h8000_1000, 0);
    fetch("err_below", 0, 32'h7FFF_FFFC, 0);
    fetch("last_word", 0, BASE + 32'hFFC, 0);

`ifndef YSYX_IMEM_RAND_DELAY_EN
    a = BASE + 32'h20;
    old = mdl[8];
    sel = 0;
    @(negedge clk); drive(0, a, 1);
    @(posedge clk);
    @(negedge clk); load_en = 1'b1; load_addr = a; load_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 load_en = 1'b0;
    mdl[8] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("coll_rvalid", 32'(if2.rvalid), 1);
    chk("coll_old", if2.rdata, old);
    @(negedge clk);
    drive(0, a, 0);
    fetch("coll_refetch", 0, a, 0);
    chk("coll_model", mdl[8], 32'hDEAD_BEEF);
`endif

    sel = 1;
    @(negedge clk); drive(1, BASE, 1);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    chk("midwait_busy", 32'(busy8), 1);
    rst8 = 1'b0;
    #1;
    chk("midwait_rvalid", 32'(if8.rvalid), 0);
    chk("midwait_busy_drop", 32'(busy8), 0);
    chk("midwait_rdata", if8.rdata, 0);
    drive(1, BASE, 0);
    @(negedge clk);
    @(negedge clk); rst8 = 1'b1;
    cnt = 0;
    repeat (15) begin @(negedge clk); cnt += int'(if8.rvalid); end
    chk("post_rst_stray", 32'(cnt), 0);
    fetch("post_rst_data", 1, BASE, 0);
    fetch("post_rst_data2", 1, BASE + 32'h14, 0);

    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 9))
        7:       a = BASE + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(1, 3));
        8:       a = BASE - 32'(4 * $urandom_range(1, 1000));
        9:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 1000));
        default: a = BASE + 32'(4 * $urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 2) == 0)
        load($urandom_range(0, 3) == 0 ? BASE + 32'(4 * DEPTH) : BASE + 32'(4 * $urandom_range(0, 63)), $urandom);
      fetch("rand", 0, a, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_imem_rsp.md
# ysyx_imem_rsp

Instruction-memory read responder for the IFU bus port: the slave end of the IFU's araddr/arvalid → rdata/rvalid read channel. It captures the fetch address, waits a programmable access latency, and returns one 32-bit word with a single-cycle rvalid pulse. It also provides a word-write preload port for boot images and testbenches. It sits between the IFU and the simulated SRAM in the SoC top.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- DEPTH, 1024, memory words; power of two
- BASE, 32'h8000_0000, byte address of word 0
- LATENCY, 2, cycles from accept to rvalid; 1..255
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ifu_araddr  in  ADDR_W  fetch byte address
- ifu_arvalid  in  1  request valid; master holds it high until it sees rvalid
- ifu_rdata  out  DATA_W  read data; valid only while ifu_rvalid=1
- ifu_rvalid  out  1  one-cycle response pulse
- ifu_rerr  out  1  error flag, qualified by ifu_rvalid
- load_en  in  1  preload write strobe
- load_addr  in  ADDR_W  preload byte address
- load_data  in  DATA_W  preload word
- busy_o  out  1  high in WAIT or RESP

## Operation
- States: IDLE, WAIT, RESP, DRAIN.
- IDLE: on a rising edge with ifu_arvalid=1, capture araddr into req_addr, load cnt=LATENCY-1, go to WAIT. If LATENCY=1, go directly to RESP.
- WAIT: decrement cnt each cycle; when cnt==0, go to RESP. ifu_arvalid and ifu_araddr are ignored.
- RESP: ifu_rvalid=1 for exactly this cycle. The captured word is presented on ifu_rdata. Next state is DRAIN.
- DRAIN: re-arm guard, because the master keeps arvalid high after rvalid.
  - arvalid=0 → IDLE.
  - arvalid=1 with araddr != req_addr → accept as a new request; same action as IDLE accept.
  - arvalid=1 with araddr == req_addr → stay in DRAIN.
- Address decode, applied to req_addr:
  - idx = (req_addr-BASE)>>2.
  - Error when req_addr[1:0]!=0, or req_addr<BASE, or idx>=DEPTH.
  - On error: rdata=0 and rerr=1. On success: rdata=mem[idx] and rerr=0.
- Data capture: the memory array is read on the edge entering RESP, into an output register.
- Preload:
  - load_en=1 with a valid aligned load_addr writes mem on that edge, in any state.
  - Invalid load addresses are dropped silently.
- Load/read collision on the same word at the RESP-entry edge: read-before-write. The response carries the old word.
- Reset mid-operation: any state → IDLE immediately.
  - rvalid, rerr, busy_o, rdata, cnt and req_addr all go to 0.
  - Memory contents are not reset.
  - An in-flight request is dropped; the master must reissue it.

## Timing
- Reset values: ifu_rvalid=0, ifu_rerr=0, ifu_rdata=0, busy_o=0, state=IDLE.
- Accept at edge k → ifu_rvalid high in the cycle after edge k+LATENCY-1. With LATENCY=1, this is the cycle immediately following the accept edge.
- Back-to-back requests: at most one response per LATENCY+1 cycles (RESP→DRAIN→accept).
- Outputs are registered; there is no combinational path from ifu_arvalid or ifu_araddr to ifu_rvalid.
- cnt is an 8-bit down-counter.

## Configuration
- YSYX_IMEM_RAND_DELAY_EN
  - Defined: a 4-bit LFSR (x^4+x^3+1, seed 4'b1001 on reset) advances every cycle. On accept, cnt loads LATENCY-1+lfsr[1:0], giving a latency in LATENCY..LATENCY+3. This stresses IFU wait handling.
  - Undefined: fixed LATENCY; no LFSR logic is present.

## Test plan
- Fixed latency:
  - Stimulus: preload mem[0]=32'h0000_0413; LATENCY=2; araddr=32'h8000_0000 with arvalid held.
  - Required: rvalid for exactly one cycle, 2 cycles after accept; rdata=32'h0000_0413; rerr=0.
- Held arvalid:
  - Stimulus: keep arvalid=1, same address, for 10 cycles after the response.
  - Required: no second rvalid.
  - Stimulus: then change araddr to 32'h8000_0004.
  - Required: new response with mem[1].
- Error decode:
  - araddr=32'h8000_0002 → rvalid with rerr=1, rdata=0.
  - araddr=32'h8000_1000 with DEPTH=1024 → rvalid with rerr=1, rdata=0.
  - araddr=32'h7FFF_FFFC → rvalid with rerr=1, rdata=0.
- Collision:
  - Stimulus: load_en writes 32'hDEAD_BEEF to the requested word on the RESP-entry edge.
  - Required: the response returns the old word; a re-fetch returns 32'hDEAD_BEEF.
- Reset mid-WAIT:
  - Stimulus: LATENCY=8; assert rst low 3 cycles after accept, asynchronously between edges.
  - Required: rvalid and busy_o drop immediately; no stray rvalid after release; preloaded data is intact.
- With YSYX_IMEM_RAND_DELAY_EN:
  - Stimulus: 100 sequential fetches.
  - Required: every latency falls in LATENCY..LATENCY+3; every rdata matches the preload.
